// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues instruction-memory requests
// and buffers in-order responses for delivery to the IF/ID register.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stop,
    input  logic        ex_redirect,
    input  logic [31:0] ex_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] fetch_pc
);

    localparam int unsigned   CW       = $clog2(BUF_DEPTH + 1);
    localparam int unsigned   PW       = $clog2(BUF_DEPTH);
    localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(BUF_DEPTH);
    localparam logic [PW-1:0] LAST_IDX = PW'(BUF_DEPTH - 1);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;

    logic [31:0]   fpc_q;
    logic [CW-1:0] inflight_q;
    logic [CW-1:0] drop_q;
    logic [CW-1:0] count_q;
    logic [PW-1:0] fifo_wr_q;
    logic [PW-1:0] fifo_rd_q;
    logic [PW-1:0] pcq_wr_q;
    logic [PW-1:0] pcq_rd_q;
    fetch_entry_t  fifo_q [BUF_DEPTH];
    logic [31:0]   pcq_q  [BUF_DEPTH];

    logic [CW:0]   credit_used;
    logic          gnt_fire;
    logic          rsp_fire;
    logic          rsp_drop;
    logic          push;
    logic          pop;
    fetch_entry_t  head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + PW'(1);
    endfunction

    // Credits count both in-flight requests and buffered words so a grant always has a slot.
    assign credit_used = {1'b0, inflight_q} + {1'b0, count_q};
    assign imem_req    = !ex_redirect && (credit_used < DEPTH_W);
    assign imem_addr   = fpc_q;
    assign fetch_pc    = fpc_q;

    assign gnt_fire = imem_req && imem_gnt;
    assign rsp_fire = imem_rvalid && (inflight_q != '0);
    assign rsp_drop = rsp_fire && ((drop_q != '0) || ex_redirect);
    assign push     = rsp_fire && !rsp_drop;

    assign head     = fifo_q[fifo_rd_q];
    assign id_valid = (count_q != '0) && !ex_redirect;
    assign id_inst  = head.inst;
    assign id_pc    = head.pc;
    assign pop      = id_valid && !stop;

    // PC, counters and queue pointers; a redirect wins over stop and any response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc_q      <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            fifo_wr_q  <= '0;
            fifo_rd_q  <= '0;
            pcq_wr_q   <= '0;
            pcq_rd_q   <= '0;
        end else begin
            if (ex_redirect) begin
                fpc_q <= ex_target;
            end else if (gnt_fire) begin
                fpc_q <= fpc_q + 32'd4;
            end

            inflight_q <= inflight_q + CW'(gnt_fire) - CW'(rsp_fire);

            if (ex_redirect) begin
                drop_q <= inflight_q - CW'(rsp_fire);
            end else if (rsp_fire && (drop_q != '0)) begin
                drop_q <= drop_q - CW'(1);
            end

            if (gnt_fire) pcq_wr_q <= ptr_inc(pcq_wr_q);
            if (rsp_fire) pcq_rd_q <= ptr_inc(pcq_rd_q);

            if (ex_redirect) begin
                count_q   <= '0;
                fifo_rd_q <= fifo_wr_q;
            end else begin
                count_q <= count_q + CW'(push) - CW'(pop);
                if (push) fifo_wr_q <= ptr_inc(fifo_wr_q);
                if (pop)  fifo_rd_q <= ptr_inc(fifo_rd_q);
            end
        end
    end

    // Granted-PC queue and response buffer storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                fifo_q[i] <= '0;
                pcq_q[i]  <= '0;
            end
        end else begin
            if (gnt_fire) pcq_q[pcq_wr_q] <= fpc_q;
            if (push)     fifo_q[fifo_wr_q] <= '{inst: imem_rdata, pc: pcq_q[pcq_rd_q]};
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order instruction-memory responder.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stop = 1'b0;
    logic        ex_redirect = 1'b0;
    logic [31:0] ex_target = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] fetch_pc;

    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          lat = 1;
    bit          gnt_rand = 1'b0;
    bit          spur = 1'b0;
    bit          sb_on = 1'b0;
    logic [31:0] sb_pc = '0;
    bit          hold_q = 1'b0;
    bit          hold_chk = 1'b0;
    logic [31:0] hold_addr = '0;
    logic [31:0] rq_addr [$];
    int          rq_due  [$];
    logic [31:0] wrap_exp [4];

    fetch_unit #(
        .RESET_PC  (RST_PC),
        .BUF_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stop        (stop),
        .ex_redirect (ex_redirect),
        .ex_target   (ex_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_inst     (id_inst),
        .id_pc       (id_pc),
        .fetch_pc    (fetch_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Present memory outputs for this cycle, let them settle, then scoreboard delivery.
    task automatic cyc_begin();
        imem_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (spur) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
        end else if (rq_addr.size() != 0 && rq_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = inst_of(rq_addr[0]);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
        #1;
        if (hold_chk && hold_q) check("addr_hold", imem_addr, hold_addr);
        if (sb_on && id_valid && !stop) begin
            check("sb_pc", id_pc, sb_pc);
            check("sb_inst", id_inst, inst_of(sb_pc));
            sb_pc += 32'd4;
        end
    endtask

    task automatic cyc_end();
        hold_q    = imem_req && !imem_gnt;
        hold_addr = imem_addr;
        if (imem_rvalid && !spur && rq_addr.size() != 0) begin
            void'(rq_addr.pop_front());
            void'(rq_due.pop_front());
        end
        if (imem_req && imem_gnt) begin
            rq_addr.push_back(imem_addr);
            rq_due.push_back(cyc + lat);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            cyc_begin();
            cyc_end();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stop = 1'b0;
        ex_redirect = 1'b0;
        ex_target = '0;
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        imem_gnt = 1'b1;
        rq_addr.delete();
        rq_due.delete();
        sb_on = 1'b0;
        hold_q = 1'b0;
        hold_chk = 1'b0;
        gnt_rand = 1'b0;
        spur = 1'b0;
        lat = 1;
        @(posedge clk);
        #1;
        check("rst_fetch_pc", fetch_pc, RST_PC);
        check("rst_imem_addr", imem_addr, RST_PC);
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_id_inst", id_inst, 32'd0);
        check("rst_id_pc", id_pc, 32'd0);
        check("rst_inflight", 32'(dut.inflight_q), 32'd0);
        check("rst_drop", 32'(dut.drop_q), 32'd0);
        check("rst_count", 32'(dut.count_q), 32'd0);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    initial begin
        // Reset, streaming and stall with 1-cycle memory.
        do_reset();
        sb_on = 1'b1;
        sb_pc = RST_PC;
        cyc_begin();
        check("c0_fetch_pc", fetch_pc, RST_PC);
        check("c0_req", 32'(imem_req), 32'd1);
        cyc_end();
        cyc_begin();
        check("c1_id_valid", 32'(id_valid), 32'd0);
        cyc_end();
        cyc_begin();
        check("c2_id_valid", 32'(id_valid), 32'd1);
        check("c2_id_pc", id_pc, RST_PC);
        cyc_end();
        run(1);
        stop = 1'b1;
        for (int k = 4; k <= 8; k++) begin
            cyc_begin();
            check("stall_pc", id_pc, 32'h0000_0108);
            check("stall_inst", id_inst, inst_of(32'h0000_0108));
            check("stall_req", 32'(imem_req), (k < 6) ? 32'd1 : 32'd0);
            cyc_end();
        end
        stop = 1'b0;
        cyc_begin();
        check("rel_req", 32'(imem_req), 32'd0);
        cyc_end();
        cyc_begin();
        check("rel_next_pc", id_pc, 32'h0000_010C);
        check("rel_req2", 32'(imem_req), 32'd1);
        cyc_end();
        for (int k = 0; k < 6; k++) begin
            cyc_begin();
            check("stream_valid", 32'(id_valid), 32'd1);
            cyc_end();
        end

        // Redirect with two requests outstanding on a 3-cycle memory.
        do_reset();
        lat = 3;
        run(2);
        ex_redirect = 1'b1;
        ex_target = 32'h0000_0200;
        cyc_begin();
        check("rd_req_off", 32'(imem_req), 32'd0);
        check("rd_valid_off", 32'(id_valid), 32'd0);
        cyc_end();
        ex_redirect = 1'b0;
        cyc_begin();
        check("rd_fetch_pc", fetch_pc, 32'h0000_0200);
        check("rd_req", 32'(imem_req), 32'd1);
        check("rd_drop", 32'(dut.drop_q), 32'd2);
        check("rd_wait_valid", 32'(id_valid), 32'd0);
        cyc_end();
        for (int k = 4; k <= 6; k++) begin
            cyc_begin();
            check("rd_wait_valid", 32'(id_valid), 32'd0);
            cyc_end();
        end
        cyc_begin();
        check("rd_valid", 32'(id_valid), 32'd1);
        check("rd_id_pc", id_pc, 32'h0000_0200);
        check("rd_id_inst", id_inst, inst_of(32'h0000_0200));
        cyc_end();
        sb_on = 1'b1;
        sb_pc = 32'h0000_0204;
        run(12);

        // Redirect during stop with a response in the same cycle.
        do_reset();
        stop = 1'b1;
        run(2);
        cyc_begin();
        check("rs_head", id_pc, RST_PC);
        cyc_end();
        ex_redirect = 1'b1;
        ex_target = 32'h0000_0300;
        cyc_begin();
        check("rs_valid_off", 32'(id_valid), 32'd0);
        check("rs_req_off", 32'(imem_req), 32'd0);
        cyc_end();
        ex_redirect = 1'b0;
        stop = 1'b0;
        cyc_begin();
        check("rs_count", 32'(dut.count_q), 32'd0);
        check("rs_drop", 32'(dut.drop_q), 32'd0);
        check("rs_fetch_pc", fetch_pc, 32'h0000_0300);
        check("rs_valid0", 32'(id_valid), 32'd0);
        cyc_end();
        cyc_begin();
        check("rs_valid1", 32'(id_valid), 32'd0);
        cyc_end();
        cyc_begin();
        check("rs_valid", 32'(id_valid), 32'd1);
        check("rs_id_pc", id_pc, 32'h0000_0300);
        cyc_end();

        // Random grant backpressure.
        do_reset();
        gnt_rand = 1'b1;
        hold_chk = 1'b1;
        sb_on = 1'b1;
        sb_pc = RST_PC;
        run(80);
        check("bp_progress", 32'(sb_pc >= RST_PC + 32'h40), 32'd1);

        // PC wrap through 0xFFFF_FFFC.
        do_reset();
        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;
        wrap_exp[3] = 32'h0000_0004;
        ex_redirect = 1'b1;
        ex_target = 32'hFFFF_FFF8;
        run(1);
        ex_redirect = 1'b0;
        run(2);
        for (int k = 0; k < 4; k++) begin
            cyc_begin();
            check("wrap_pc", id_pc, wrap_exp[k]);
            check("wrap_inst", id_inst, inst_of(wrap_exp[k]));
            cyc_end();
        end

        // Reset pulsed with two requests in flight, then a stray response.
        do_reset();
        lat = 3;
        run(2);
        cyc_begin();
        check("mr_inflight_pre", 32'(dut.inflight_q), 32'd2);
        rst_n = 1'b0;
        #1;
        check("mr_inflight", 32'(dut.inflight_q), 32'd0);
        check("mr_drop", 32'(dut.drop_q), 32'd0);
        check("mr_count", 32'(dut.count_q), 32'd0);
        check("mr_id_valid", 32'(id_valid), 32'd0);
        check("mr_fetch_pc", fetch_pc, RST_PC);
        do_reset();
        spur = 1'b1;
        cyc_begin();
        check("sp_req", 32'(imem_req), 32'd1);
        cyc_end();
        spur = 1'b0;
        cyc_begin();
        check("sp_valid", 32'(id_valid), 32'd0);
        check("sp_inflight", 32'(dut.inflight_q), 32'd1);
        cyc_end();
        cyc_begin();
        check("sp_id_pc", id_pc, RST_PC);
        check("sp_id_inst", id_inst, inst_of(RST_PC));
        cyc_end();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
